// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the memory pipeline stage.
//   XLEN          datapath / address width
//   F3_*          funct3 encodings for load/store size and sign
//   mem_state_t   memory-stage bus FSM states
//   natural_align clears the low address bits an access size cannot use
//   is_misaligned flags an address that is not naturally aligned for its size
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } mem_state_t;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic [XLEN-1:0] natural_align(input logic [2:0] f3,
                                                      input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] a;
        a = addr;
        case (f3[1:0])
            2'b01:   a[0]   = 1'b0;
            2'b10:   a[1:0] = 2'b00;
            default: a      = addr;
        endcase
        return a;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic m;
        case (f3[1:0])
            2'b01:   m = lane[0];
            2'b10:   m = (lane != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the memory stage.
//   funct3      access size/sign
//   lane        byte offset within the word (address bits [1:0])
//   store_data  raw store data (rs2)
//   load_word   full word returned by the bus
//   be          store byte enables
//   wdata       store data replicated across all lanes of its size
//   load_data   load result extracted from its lane and sign/zero extended
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store side: replicate the datum so the slave can pick it from any enabled lane.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {lane[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            default: begin
                be    = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Load side: pick the addressed byte/halfword, then extend per funct3[2].
    always_comb begin
        case (lane)
            2'b00:   byte_s = load_word[7:0];
            2'b01:   byte_s = load_word[15:8];
            2'b10:   byte_s = load_word[23:16];
            2'b11:   byte_s = load_word[31:24];
            default: byte_s = load_word[7:0];
        endcase
        half_s = lane[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'h000000, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'h0000, half_s};
            F3_W:    load_data = load_word;
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline stage 4 (EX/MEM -> MEM/WB).
// Issues data-memory loads/stores over a req/ready + rvalid bus, aligns load
// data, builds store byte enables, and registers results into MEM_WB_*.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   hazard_stall / hazard_flush    hold / bubble the MEM_WB_* register
//   EX_MEM_*                       instruction from EX (stable while mem_busy)
//   dmem_req/we/addr/wdata/be      bus request channel (req held until ready)
//   dmem_ready/rvalid/rdata        bus accept and load-data return
//   mem_busy                       stall request while a transaction is open
//   MEM_WB_*                       registered results for writeback
//   mem_misaligned                 (MEM_MISALIGN_TRAP_EN only) 1-cycle pulse
// Build option MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and
// complete with RegWrite suppressed; otherwise low address bits are masked.
module mem_stage
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN
)(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            hazard_stall,
    input  logic            hazard_flush,
    input  logic [XLEN-1:0] EX_MEM_PC,
    input  logic [XLEN-1:0] EX_MEM_ALUResult,
    input  logic [XLEN-1:0] EX_MEM_WriteData,
    input  logic [4:0]      EX_MEM_Rd,
    input  logic            EX_MEM_RegWrite,
    input  logic            EX_MEM_MemToReg,
    input  logic            EX_MEM_MemRead,
    input  logic            EX_MEM_MemWrite,
    input  logic [2:0]      EX_MEM_Funct3,
    input  logic            EX_MEM_enable_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            mem_busy,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            mem_misaligned,
`endif
    output logic [XLEN-1:0] MEM_WB_PC,
    output logic [XLEN-1:0] MEM_WB_ALUResult,
    output logic [XLEN-1:0] MEM_WB_ReadData,
    output logic [4:0]      MEM_WB_Rd,
    output logic            MEM_WB_RegWrite,
    output logic            MEM_WB_MemToReg,
    output logic            MEM_WB_enable_out
);

    mem_state_t      state_r, state_nxt_s;
    logic            kill_r, kill_nxt_s;
    logic [XLEN-1:0] rdata_r;       // aligned load result held for the DONE state
    logic            mem_op_s, is_store_s, is_load_s, mis_s;
    logic [XLEN-1:0] addr_eff_s, load_data_s, wb_rdata_s;
    logic            req_s, complete_s, write_s, busy_s;

    assign mem_op_s   = EX_MEM_enable_out & (EX_MEM_MemRead | EX_MEM_MemWrite);
    assign is_store_s = mem_op_s & EX_MEM_MemWrite;   // read+write counts as a store
    assign is_load_s  = mem_op_s & ~EX_MEM_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_s      = mem_op_s & is_misaligned(EX_MEM_Funct3, EX_MEM_ALUResult[1:0]);
    assign addr_eff_s = EX_MEM_ALUResult;
`else
    assign mis_s      = 1'b0;
    assign addr_eff_s = natural_align(EX_MEM_Funct3, EX_MEM_ALUResult);
`endif

    lsu_align u_align (
        .funct3     (EX_MEM_Funct3),
        .lane       (addr_eff_s[1:0]),
        .store_data (EX_MEM_WriteData),
        .load_word  (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data_s)
    );

    // Bus FSM control: request, completion, result-write and next state.
    // A completion that meets hazard_stall parks in DONE so the result is not
    // lost and the still-present EX_MEM instruction is not re-issued.
    always_comb begin
        state_nxt_s = state_r;
        req_s       = 1'b0;
        complete_s  = 1'b0;
        write_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!mem_op_s || mis_s) begin
                    complete_s  = 1'b1;
                    write_s     = 1'b1;
                    state_nxt_s = (mem_op_s && hazard_stall) ? DONE : IDLE;
                end else begin
                    req_s = 1'b1;
                    if (dmem_ready && is_store_s) begin
                        complete_s  = 1'b1;
                        write_s     = 1'b1;
                        state_nxt_s = hazard_stall ? DONE : IDLE;
                    end else begin
                        state_nxt_s = dmem_ready ? RESP : REQ;
                    end
                end
            end
            REQ: begin
                req_s = 1'b1;
                if (dmem_ready && is_store_s) begin
                    complete_s  = 1'b1;
                    write_s     = ~kill_r;
                    state_nxt_s = hazard_stall ? DONE : IDLE;
                end else begin
                    state_nxt_s = dmem_ready ? RESP : REQ;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    complete_s  = 1'b1;
                    write_s     = ~kill_r;
                    state_nxt_s = hazard_stall ? DONE : IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            DONE: begin
                write_s     = ~kill_r;
                state_nxt_s = hazard_stall ? DONE : IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
        // A flush while a transaction is open poisons its result until IDLE.
        kill_nxt_s = (state_nxt_s == IDLE) ? 1'b0 : (kill_r | hazard_flush);
        case (state_r)
            IDLE:    busy_s = mem_op_s & ~complete_s;
            REQ:     busy_s = ~complete_s;
            RESP:    busy_s = ~complete_s;
            default: busy_s = 1'b0;
        endcase
        if (is_load_s && !mis_s) begin
            wb_rdata_s = (state_r == DONE) ? rdata_r : load_data_s;
        end else begin
            wb_rdata_s = {XLEN{1'b0}};
        end
    end

    // Bus-facing outputs are forced quiet while reset is asserted.
    assign dmem_req  = reset_n & req_s;
    assign dmem_we   = reset_n & req_s & is_store_s;
    assign mem_busy  = reset_n & busy_s;
    assign dmem_addr = {addr_eff_s[XLEN-1:2], 2'b00};

    // FSM state, kill flag and captured load data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            kill_r  <= 1'b0;
            rdata_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            kill_r  <= kill_nxt_s;
            if (state_r == RESP && dmem_rvalid) begin
                rdata_r <= load_data_s;
            end
        end
    end

    // MEM/WB pipeline register: flush > stall > result write > bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || hazard_flush) begin
            MEM_WB_PC         <= {XLEN{1'b0}};
            MEM_WB_ALUResult  <= {XLEN{1'b0}};
            MEM_WB_ReadData   <= {XLEN{1'b0}};
            MEM_WB_Rd         <= 5'd0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_MemToReg   <= 1'b0;
            MEM_WB_enable_out <= 1'b0;
        end else if (hazard_stall) begin
            MEM_WB_PC         <= MEM_WB_PC;
            MEM_WB_ALUResult  <= MEM_WB_ALUResult;
            MEM_WB_ReadData   <= MEM_WB_ReadData;
            MEM_WB_Rd         <= MEM_WB_Rd;
            MEM_WB_RegWrite   <= MEM_WB_RegWrite;
            MEM_WB_MemToReg   <= MEM_WB_MemToReg;
            MEM_WB_enable_out <= MEM_WB_enable_out;
        end else if (write_s && EX_MEM_enable_out) begin
            MEM_WB_PC         <= EX_MEM_PC;
            MEM_WB_ALUResult  <= EX_MEM_ALUResult;
            MEM_WB_ReadData   <= wb_rdata_s;
            MEM_WB_Rd         <= EX_MEM_Rd;
            MEM_WB_RegWrite   <= EX_MEM_RegWrite & ~mis_s;
            MEM_WB_MemToReg   <= EX_MEM_MemToReg;
            MEM_WB_enable_out <= 1'b1;
        end else begin
            MEM_WB_PC         <= {XLEN{1'b0}};
            MEM_WB_ALUResult  <= {XLEN{1'b0}};
            MEM_WB_ReadData   <= {XLEN{1'b0}};
            MEM_WB_Rd         <= 5'd0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_MemToReg   <= 1'b0;
            MEM_WB_enable_out <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misalignment pulse accompanies the writeback of the trapped access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_misaligned <= 1'b0;
        end else begin
            mem_misaligned <= mis_s & write_s & ~hazard_stall & ~hazard_flush;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage. Expected MEM_WB
// results are queued when an instruction is driven and popped when the stage
// writes it back. Inputs change and outputs are sampled away from posedge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset_n, hazard_stall, hazard_flush;
    logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
    logic [4:0]  EX_MEM_Rd;
    logic        EX_MEM_RegWrite, EX_MEM_MemToReg, EX_MEM_MemRead, EX_MEM_MemWrite;
    logic [2:0]  EX_MEM_Funct3;
    logic        EX_MEM_enable_out;
    logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid, mem_busy;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData;
    logic [4:0]  MEM_WB_Rd;
    logic        MEM_WB_RegWrite, MEM_WB_MemToReg, MEM_WB_enable_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_misaligned;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        logic        mtr;
    } wb_t;

    wb_t wb_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall), .hazard_flush(hazard_flush),
        .EX_MEM_PC(EX_MEM_PC), .EX_MEM_ALUResult(EX_MEM_ALUResult),
        .EX_MEM_WriteData(EX_MEM_WriteData), .EX_MEM_Rd(EX_MEM_Rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemToReg(EX_MEM_MemToReg),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_Funct3(EX_MEM_Funct3), .EX_MEM_enable_out(EX_MEM_enable_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .mem_busy(mem_busy),
`ifdef MEM_MISALIGN_TRAP_EN
        .mem_misaligned(mem_misaligned),
`endif
        .MEM_WB_PC(MEM_WB_PC), .MEM_WB_ALUResult(MEM_WB_ALUResult),
        .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_Rd(MEM_WB_Rd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemToReg(MEM_WB_MemToReg),
        .MEM_WB_enable_out(MEM_WB_enable_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic mtr,
                         input logic mr, input logic mw, input logic [2:0] f3, input logic en);
        EX_MEM_PC = pc;  EX_MEM_ALUResult = alu; EX_MEM_WriteData = wd;
        EX_MEM_Rd = rd;  EX_MEM_RegWrite = rw;   EX_MEM_MemToReg = mtr;
        EX_MEM_MemRead = mr; EX_MEM_MemWrite = mw; EX_MEM_Funct3 = f3;
        EX_MEM_enable_out = en;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [4:0] rd, input logic rw, input logic mtr);
        wb_t e;
        e.pc = pc; e.alu = alu; e.rdata = rdata; e.rd = rd; e.rw = rw; e.mtr = mtr;
        wb_q.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_t e;
        vectors++;
        assert (wb_q.size() > 0) else begin
            miscompares++;
            $error("FAIL %s: scoreboard observed 0 entries, required at least 1", tag);
        end
        if (wb_q.size() > 0) begin
            e = wb_q.pop_front();
            chk({tag, "_en"},    32'(MEM_WB_enable_out), 32'd1);
            chk({tag, "_pc"},    MEM_WB_PC,              e.pc);
            chk({tag, "_alu"},   MEM_WB_ALUResult,       e.alu);
            chk({tag, "_rdata"}, MEM_WB_ReadData,        e.rdata);
            chk({tag, "_rd"},    32'(MEM_WB_Rd),         32'(e.rd));
            chk({tag, "_rw"},    32'(MEM_WB_RegWrite),   32'(e.rw));
            chk({tag, "_mtr"},   32'(MEM_WB_MemToReg),   32'(e.mtr));
        end
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, "_en"},    32'(MEM_WB_enable_out), 32'd0);
        chk({tag, "_rw"},    32'(MEM_WB_RegWrite),   32'd0);
        chk({tag, "_rd"},    32'(MEM_WB_Rd),         32'd0);
        chk({tag, "_pc"},    MEM_WB_PC,              32'd0);
        chk({tag, "_rdata"}, MEM_WB_ReadData,        32'd0);
    endtask

    // Load with immediate ready and rvalid one cycle later.
    task automatic do_load(input logic [31:0] pc, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [31:0] word,
                           input logic [31:0] exp_rdata, input logic [31:0] exp_addr,
                           input string tag);
        drive(pc, addr, 32'h0, rd, 1'b1, 1'b1, 1'b1, 1'b0, f3, 1'b1);
        push(pc, addr, exp_rdata, rd, 1'b1, 1'b1);
        dmem_ready = 1'b1;
        #1;
        chk({tag, "_busy0"}, 32'(mem_busy), 32'd1);
        chk({tag, "_req0"},  32'(dmem_req), 32'd1);
        chk({tag, "_we"},    32'(dmem_we),  32'd0);
        chk({tag, "_addr"},  dmem_addr,     exp_addr);
        tick();
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = word;
        #1;
        chk({tag, "_busy1"}, 32'(mem_busy), 32'd0);
        chk({tag, "_req1"},  32'(dmem_req), 32'd0);
        chk({tag, "_bub"},   32'(MEM_WB_enable_out), 32'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        check_wb(tag);
    endtask

    // Store with dmem_ready withheld for 'delay' cycles.
    task automatic do_store(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                            input int delay, input string tag);
        int req_cnt = 0;
        int busy_cnt = 0;
        drive(pc, addr, data, rd, 1'b0, 1'b0, 1'b0, 1'b1, f3, 1'b1);
        push(pc, addr, 32'h0, rd, 1'b0, 1'b0);
        for (int i = 0; i <= delay; i++) begin
            dmem_ready = (i == delay);
            #1;
            req_cnt  += int'(dmem_req);
            busy_cnt += int'(mem_busy);
            chk({tag, "_we"},    32'(dmem_we), 32'd1);
            chk({tag, "_be"},    32'(dmem_be), 32'(exp_be));
            chk({tag, "_wdata"}, dmem_wdata,   exp_wdata);
            chk({tag, "_addr"},  dmem_addr,    exp_addr);
            tick();
        end
        dmem_ready = 1'b0;
        chk({tag, "_reqcyc"},  32'(req_cnt),  32'(delay + 1));
        chk({tag, "_busycyc"}, 32'(busy_cnt), 32'(delay));
        check_wb(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; hazard_stall = 1'b0; hazard_flush = 1'b0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick(); tick();
        chk("rst_en",   32'(MEM_WB_enable_out), 32'd0);
        chk("rst_alu",  MEM_WB_ALUResult,       32'd0);
        chk("rst_req",  32'(dmem_req),          32'd0);
        chk("rst_busy", 32'(mem_busy),          32'd0);
        chk("rst_we",   32'(dmem_we),           32'd0);
        reset_n = 1'b1;
        tick();

        // Plain ALU op: one-cycle registration, never busy.
        drive(32'h100, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        push(32'h100, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0);
        #1;
        chk("alu_busy", 32'(mem_busy), 32'd0);
        chk("alu_req",  32'(dmem_req), 32'd0);
        tick();
        check_wb("alu");

        // Loads: byte/halfword extraction and extension.
        do_load(32'h104, 32'h1003, 5'd6, 3'b000, 32'h80FF_FF00, 32'hFFFF_FF80, 32'h1000, "lb");
        do_load(32'h108, 32'h1003, 5'd6, 3'b100, 32'h80FF_FF00, 32'h0000_0080, 32'h1000, "lbu");
        do_load(32'h10C, 32'h1002, 5'd7, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 32'h1000, "lh");
        do_load(32'h110, 32'h1000, 5'd7, 3'b101, 32'h8001_8FFF, 32'h0000_8FFF, 32'h1000, "lhu");

        // Stores: byte enables, lane replication, delayed ready.
        do_store(32'h114, 32'h2002, 32'hABCD_1234, 3'b001, 5'd7, 4'b1100, 32'h1234_1234, 32'h2000, 3, "sh");
        do_store(32'h118, 32'h2001, 32'h0000_00A5, 3'b000, 5'd0, 4'b0010, 32'hA5A5_A5A5, 32'h2000, 0, "sb");
        do_store(32'h11C, 32'h2004, 32'h0102_0304, 3'b010, 5'd0, 4'b1111, 32'h0102_0304, 32'h2004, 1, "sw");

        // LW whose rvalid coincides with a two-cycle stall.
        drive(32'h120, 32'h4000, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
        push(32'h120, 32'h4000, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF; hazard_stall = 1'b1;
        #1;
        chk("stall_busy", 32'(mem_busy), 32'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        #1;
        chk("stall_req",   32'(dmem_req),          32'd0);
        chk("stall_hold1", 32'(MEM_WB_enable_out), 32'd0);
        tick();
        hazard_stall = 1'b0;
        #1;
        chk("stall_hold2", 32'(MEM_WB_enable_out), 32'd0);
        chk("stall_busy2", 32'(mem_busy),          32'd0);
        tick();
        check_wb("lw_stall");

        // Flush while waiting for rvalid: result discarded, no writeback.
        drive(32'h124, 32'h5004, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0; hazard_flush = 1'b1;
        #1;
        chk("flush_busy", 32'(mem_busy), 32'd1);
        tick();
        hazard_flush = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        #1;
        chk("flush_busy_end", 32'(mem_busy), 32'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        check_bubble("flush_wb");
        chk("flush_sb", 32'(wb_q.size()), 32'd0);
        drive(32'h128, 32'h55, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        push(32'h128, 32'h55, 32'h0, 5'd10, 1'b1, 1'b0);
        tick();
        check_wb("alu_after_flush");

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned LW traps: no bus request, RegWrite dropped, pulse.
        drive(32'h12C, 32'h3001, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
        push(32'h12C, 32'h3001, 32'h0, 5'd11, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        #1;
        chk("trap_req",  32'(dmem_req), 32'd0);
        chk("trap_busy", 32'(mem_busy), 32'd0);
        tick();
        dmem_ready = 1'b0;
        chk("trap_pulse", 32'(mem_misaligned), 32'd1);
        check_wb("lw_trap");
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        chk("trap_pulse_end", 32'(mem_misaligned), 32'd0);
        check_bubble("trap_after");
`else
        // Misaligned accesses are masked to natural alignment.
        do_load(32'h12C, 32'h3001, 5'd11, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h3000, "lw_mask");
        do_load(32'h130, 32'h3003, 5'd12, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001, 32'h3000, "lh_mask");
`endif

        // Reset asserted mid-REQ clears outputs without waiting for a clock.
        drive(32'h134, 32'h77, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
        push(32'h134, 32'h77, 32'h0, 5'd13, 1'b1, 1'b0);
        tick();
        check_wb("alu_pre_rst");
        drive(32'h138, 32'h6000, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
        dmem_ready = 1'b0; hazard_stall = 1'b1;
        tick();
        #1;
        chk("rst_pre_req",  32'(dmem_req),          32'd1);
        chk("rst_pre_hold", 32'(MEM_WB_enable_out), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req",  32'(dmem_req),          32'd0);
        chk("rst_mid_busy", 32'(mem_busy),          32'd0);
        chk("rst_mid_we",   32'(dmem_we),           32'd0);
        chk("rst_mid_en",   32'(MEM_WB_enable_out), 32'd0);
        chk("rst_mid_alu",  MEM_WB_ALUResult,       32'd0);
        chk("rst_mid_pc",   MEM_WB_PC,              32'd0);
        hazard_stall = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_after_busy", 32'(mem_busy), 32'd0);
        tick();
        chk("end_sb", 32'(wb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage 4. Sits between the EX stage (EX_MEM_* inputs) and the WB stage (MEM_WB_* outputs).
- Performs data-memory loads and stores over a req/ready + rvalid bus, aligns and extends load data, and generates byte enables for stores.
- Registers results into the MEM_WB_* pipeline outputs.
- Raises mem_busy so the hazard unit stalls upstream stages while a bus transaction is in flight.

Parameters:
- XLEN, 32, datapath/address width (only 32 supported)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active low
- hazard_stall  in  1  global stall; hold MEM_WB_* outputs
- hazard_flush  in  1  global flush; bubble MEM_WB_* outputs
- EX_MEM_PC  in  32  PC of instruction
- EX_MEM_ALUResult  in  32  ALU result / effective address
- EX_MEM_WriteData  in  32  store data (rs2)
- EX_MEM_Rd  in  5  destination register
- EX_MEM_RegWrite  in  1  register write enable
- EX_MEM_MemToReg  in  1  select load data for writeback
- EX_MEM_MemRead  in  1  load
- EX_MEM_MemWrite  in  1  store
- EX_MEM_Funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- EX_MEM_enable_out  in  1  EX stage holds a valid instruction
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data word
- mem_busy  out  1  stall request to hazard unit
- MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData  out  32 each  registered results
- MEM_WB_Rd  out  5; MEM_WB_RegWrite, MEM_WB_MemToReg, MEM_WB_enable_out  out  1 each

Behaviour:
- Reset (async, reset_n low): state IDLE, kill flag 0, all MEM_WB_* outputs 0. dmem_req, mem_busy and dmem_we are 0.
- Output register priority: reset > hazard_flush (all MEM_WB_* to 0) > hazard_stall (hold) > normal update.
- mem_op = EX_MEM_enable_out & (EX_MEM_MemRead | EX_MEM_MemWrite). If both read and write are set, the access is treated as a store.
- FSM states:
  - IDLE: a non-memory op, or enable_out=0, registers in 1 cycle. enable_out=0 registers a bubble (all 0). A mem_op asserts dmem_req combinationally.
    - Store: if dmem_ready, complete this cycle; otherwise go to REQ.
    - Load: if dmem_ready, go to RESP; otherwise go to REQ.
  - REQ: hold dmem_req and payload stable until dmem_ready. On ready, a store completes and a load goes to RESP.
  - RESP: wait for dmem_rvalid. Capture the aligned result into rdata_q, then complete.
  - DONE: entered when completion coincides with hazard_stall. Holds the result, with dmem_req=0. Writes outputs and returns to IDLE on the first cycle with !hazard_stall.
- mem_busy = mem_op & ~(completing this cycle). The EX_MEM_* inputs are stable while mem_busy=1. MEM_WB_enable_out=0 (bubble) each unstalled cycle while busy.
- Minimum latency: store 1 cycle; load 2 cycles (ready in cycle 0, rvalid in cycle 1, outputs valid after cycle 1 edge).
- Loads, using byte lane addr[1:0]:
  - LB/LBU: byte at offset 8*addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword at addr[1]*16, sign- or zero-extended.
  - LW: full word.
- Stores:
  - SB: be = 0001<<addr[1:0], wdata = {4{b}}.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = {2{h}}.
  - SW: be = 1111.
- dmem_we=0 for loads, and be is don't-care.
- hazard_flush during REQ or RESP: bus handshakes still complete (req held to ready, rvalid awaited). The kill flag is set, the result is discarded with no MEM_WB update, mem_busy stays 1 until the transaction ends, and the kill flag clears on return to IDLE. A flush in DONE discards the held result.
- Reset mid-transaction: the FSM returns to IDLE immediately. The bus slave is reset by the same reset_n.
- MEM_WB_ReadData = 0 for non-load instructions.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access (H with addr[0]=1, W with addr[1:0]!=0) issues no bus request and completes in 1 cycle with MEM_WB_RegWrite forced to 0. A new output mem_misaligned (1 bit, registered, reset 0) pulses high for 1 cycle.
- Undefined: the low address bits are masked to natural alignment (H: addr[0]=0, W: addr[1:0]=0) and the access proceeds normally; the mem_misaligned port is absent.

Decomposition:
- Shared package core_pkg:
  - funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - mem_state_t enum {IDLE, REQ, RESP, DONE}.
  - XLEN.
- One combinational sub-module, lsu_align: produces be, wdata replication and load extract/extend from funct3, addr[1:0] and data.

Test Plan:
- ALU op (RegWrite=1, Rd=5, ALUResult=0x1234) with enable_out=1, no mem -> next edge MEM_WB_ALUResult=0x1234, MEM_WB_Rd=5, MEM_WB_enable_out=1, mem_busy never 1.
- LB addr 0x1003, rdata=0x80FF_FF00, ready immediate, rvalid 1 cycle later -> MEM_WB_ReadData=0xFFFF_FF80, mem_busy high for exactly 1 cycle. LBU at the same address -> 0x0000_0080.
- SH addr 0x2002, data 0xABCD1234, ready delayed 3 cycles -> dmem_be=1100, wdata=0x12341234, dmem_req held for 4 cycles, mem_busy=1 for 3 cycles, MEM_WB_RegWrite=0.
- LW with rvalid coinciding with hazard_stall=1 for 2 cycles -> outputs held; MEM_WB_ReadData updates on the first unstalled edge; no data lost.
- hazard_flush asserted in RESP -> rvalid consumed, MEM_WB_* stay 0, mem_busy drops after rvalid, the next instruction proceeds normally.
- reset_n low during REQ -> dmem_req=0, MEM_WB_* = 0 immediately (asynchronously); with MEM_MISALIGN_TRAP_EN, LW at 0x3001 -> no dmem_req, mem_misaligned=1 for 1 cycle, MEM_WB_RegWrite=0.
